conv_8b_to_32b: RTL

//  Receive-side counterpart of the 32b->8b serializer: packs a stream of 8-bit

---
 rtl/conv_8b_to_32b.sv | 89 ++++++++
 1 files changed

// File: rtl/conv_8b_to_32b.sv
// Byte-to-word packer: collects BYTES consecutive valid bytes (first byte is the MSB)
// into one word, holds valid_out long enough for a clk_4f/BYTES consumer, flags aborted words.
module conv_8b_to_32b #(
   parameter int BYTE_W = 8,
   parameter int BYTES  = 4
) (
   input  logic                      clk_4f,
   input  logic                      reset_L,
   input  logic                      valid_in,
   input  logic [BYTE_W-1:0]         data_in,
   output logic                      valid_out,
   output logic [BYTE_W*BYTES-1:0]   data_out,
   output logic                      frame_err
);

   localparam int OUT_W = BYTE_W * BYTES;
   localparam int SH_W  = BYTE_W * (BYTES - 1);
   localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

   typedef enum logic {
      IDLE,
      ASSEMBLE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  hold_cnt;
   logic [SH_W-1:0]   shift;
   logic              word_done;

   // The last byte of a word arrives while cnt already counts BYTES-1 captured bytes.
   assign word_done = (state == ASSEMBLE) && valid_in && (cnt == LAST);

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         state     <= IDLE;
         cnt       <= '0;
         hold_cnt  <= '0;
         shift     <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;

         case (state)
            IDLE: begin
               if (valid_in) begin
                  shift <= SH_W'(data_in);
                  cnt   <= CNT_W'(1);
                  state <= ASSEMBLE;
               end
            end
            ASSEMBLE: begin
               if (!valid_in) begin
                  // A gap inside a word drops the partial bytes; the last good word stays on data_out.
                  cnt       <= '0;
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end else if (cnt == LAST) begin
                  data_out <= OUT_W'({shift, data_in});
                  cnt      <= '0;
                  state    <= IDLE;
               end else begin
                  shift <= (shift << BYTE_W) | SH_W'(data_in);
                  cnt   <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase

         // valid_out stays up for BYTES edges after the last completion; a new word reloads it.
         if (word_done) begin
            valid_out <= 1'b1;
            hold_cnt  <= LAST;
         end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
         end else begin
            valid_out <= 1'b0;
         end
      end
   end

endmodule
